branch_history_ctrl: RTL and testbench



---
 rtl/bp_pkg.sv | 27 ++
 rtl/bht_array.sv | 38 +++
 rtl/branch_history_ctrl.sv | 125 ++++++++++++
 tb/tb_branch_history_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch history table controller.
//   BHT_SNT/BHT_WNT/BHT_WT/BHT_ST : 2-bit saturating counter encodings
//   bht_state_t                   : controller state (INIT sweep / RUN)
//   sat_next(state, taken)        : next counter value after a resolved branch
package bp_pkg;

  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bht_state_t;

  function automatic logic [1:0] sat_next(input logic [1:0] state, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (state == BHT_ST) ? BHT_ST : state + 2'd1;
    end else begin
      res = (state == BHT_SNT) ? BHT_SNT : state - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_array.sv
// Table of 2^IDX_W two-bit saturating counters.
//   clk_in   : clock
//   we       : write enable for this cycle
//   wr_idx   : entry written
//   wr_init  : 1 = load the weak-not-taken reset value, 0 = saturating update
//   wr_taken : branch outcome used by the saturating update
//   rd_idx   : asynchronous lookup index
//   rd_data  : counter at rd_idx (pre-write value in a same-cycle collision)
module bht_array
  import bp_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk_in,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_init,
  input  logic             wr_taken,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_data
);

  localparam int DEPTH = 1 << IDX_W;

  // No reset: contents are defined by the controller's init sweep.
  logic [1:0] entry_q [DEPTH];

  // The write port owns its own read of the target entry so the update is a
  // single-cycle read-modify-write; the lookup port stays independent.
  always_ff @(posedge clk_in) begin
    if (we) begin
      entry_q[wr_idx] <= wr_init ? BHT_WNT : sat_next(entry_q[wr_idx], wr_taken);
    end
  end

  assign rd_data = entry_q[rd_idx];

endmodule

// File: rtl/branch_history_ctrl.sv
// Branch history table controller: 1-cycle prediction lookup, one resolved
// outcome update per cycle, post-reset table initialisation sweep and a
// committed-misprediction counter.
//   clk_in, rst_in       : clock, synchronous active-high reset
//   rdy_in               : global ready; low freezes every register
//   busy                 : init sweep in progress (requests ignored)
//   pred_req/pred_pc     : lookup request and branch PC
//   pred_valid/pred_taken: registered lookup result, one cycle later
//   upd_valid/upd_pc/upd_taken/upd_mispredict : resolved branch outcome
//   mispredict_cnt       : wrapping count of accepted mispredictions
module branch_history_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  output logic             busy,
  input  logic             pred_req,
  input  logic [31:0]      pred_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  bht_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic             arr_we, arr_init;
  logic [IDX_W-1:0] arr_wr_idx;
  logic [1:0]       arr_rd_data;

  // Word-aligned PC bits select the entry; no tag, so aliasing is expected.
  assign pred_idx = pred_pc[IDX_W+1:2];
  assign upd_idx  = upd_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                            upd_pc[31:IDX_W+2], upd_pc[1:0]};

  bht_array #(.IDX_W(IDX_W)) u_array (
    .clk_in   (clk_in),
    .we       (arr_we),
    .wr_idx   (arr_wr_idx),
    .wr_init  (arr_init),
    .wr_taken (upd_taken),
    .rd_idx   (pred_idx),
    .rd_data  (arr_rd_data)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pred_valid_d = pred_valid_q;
    pred_taken_d = pred_taken_q;
    cnt_d        = cnt_q;
    arr_we       = 1'b0;
    arr_init     = 1'b1;
    arr_wr_idx   = ptr_q;

    if (rdy_in && !rst_in) begin
      case (state_q)
        INIT: begin
          arr_we       = 1'b1;
          ptr_d        = ptr_q + IDX_W'(1);
          pred_valid_d = 1'b0;
          if (ptr_q == LAST_IDX) begin
            state_d = RUN;
          end
        end
        RUN: begin
          pred_valid_d = pred_req;
          // Async read sees the pre-update value, giving read-before-write
          // when lookup and update hit the same entry.
          if (pred_req) begin
            pred_taken_d = arr_rd_data[1];
          end
          if (upd_valid) begin
            arr_we     = 1'b1;
            arr_init   = 1'b0;
            arr_wr_idx = upd_idx;
            if (upd_mispredict) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      cnt_q        <= cnt_d;
    end
  end

  assign busy           = (state_q == INIT);
  assign pred_valid     = pred_valid_q;
  assign pred_taken     = pred_taken_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_history_ctrl.sv
module tb_branch_history_ctrl;

  localparam int IDX_W = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, pred_req, upd_valid, upd_taken, upd_mis;
  logic [31:0] pred_pc, upd_pc;
  logic        busy, pv, pt, busy2, pv2, pt2;
  logic [31:0] cnt;
  logic [1:0]  cnt2;

  branch_history_ctrl #(.IDX_W(IDX_W), .CNT_W(32)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .busy(busy),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_valid(pv), .pred_taken(pt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_mispredict(upd_mis), .mispredict_cnt(cnt)
  );

  branch_history_ctrl #(.IDX_W(IDX_W), .CNT_W(2)) dut_w (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .busy(busy2),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_valid(pv2), .pred_taken(pt2),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_mispredict(upd_mis), .mispredict_cnt(cnt2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: table of integer counters, number of sweep
  // writes still owed, last prediction outputs and the mispredict tally.
  int          m_tbl [DEPTH];
  int          m_init_left = 0;
  bit          m_known = 0;
  bit          m_pv = 0, m_pt = 0;
  int unsigned m_cnt = 0;
  int          m_pi, m_ui;

  always @(posedge clk) begin
    if (rst) begin
      m_known     = 1;
      m_init_left = DEPTH;
      m_pv        = 0;
      m_pt        = 0;
      m_cnt       = 0;
    end else if (rdy && m_known) begin
      if (m_init_left > 0) begin
        m_tbl[DEPTH - m_init_left] = 1;
        m_init_left--;
        m_pv = 0;
      end else begin
        m_pi = int'(pred_pc[7:2]);
        m_ui = int'(upd_pc[7:2]);
        m_pv = pred_req;
        if (pred_req) m_pt = (m_tbl[m_pi] >= 2);
        if (upd_valid) begin
          if (upd_taken) m_tbl[m_ui] = (m_tbl[m_ui] == 3) ? 3 : m_tbl[m_ui] + 1;
          else           m_tbl[m_ui] = (m_tbl[m_ui] == 0) ? 0 : m_tbl[m_ui] - 1;
          if (upd_mis) m_cnt++;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_known) begin
      chk("busy",       {31'd0, busy},  {31'd0, m_init_left > 0});
      chk("pred_valid", {31'd0, pv},    {31'd0, m_pv});
      chk("pred_taken", {31'd0, pt},    {31'd0, m_pt});
      chk("mis_cnt",    cnt,            m_cnt);
      chk("busy_w",     {31'd0, busy2}, {31'd0, m_init_left > 0});
      chk("pred_valid_w", {31'd0, pv2}, {31'd0, m_pv});
      chk("pred_taken_w", {31'd0, pt2}, {31'd0, m_pt});
      chk("mis_cnt_w",  {30'd0, cnt2},  m_cnt % 4);
    end
  end

  task automatic idle();
    pred_req = 0; upd_valid = 0; upd_taken = 0; upd_mis = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  // Counts cycles with busy high (bounded); notes any pred_valid seen.
  task automatic wait_sweep(output int n, output bit saw_pv);
    n = 0; saw_pv = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      if (pv === 1'b1) saw_pv = 1;
      @(negedge clk);
    end
  endtask

  task automatic look(input logic [31:0] pc, input bit exp, input string name);
    pred_req = 1; pred_pc = pc;
    @(negedge clk);
    pred_req = 0;
    chk({name, "_valid"}, {31'd0, pv}, 32'd1);
    chk(name, {31'd0, pt}, {31'd0, exp});
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input bit mis);
    upd_valid = 1; upd_pc = pc; upd_taken = t; upd_mis = mis;
    @(negedge clk);
    upd_valid = 0; upd_mis = 0;
  endtask

  int n;
  bit saw;
  bit sat_exp_t [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  bit sat_exp_n [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    idle();
    rst = 1; rdy = 1; pred_pc = 0; upd_pc = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Reset sweep: 64 busy cycles, requests ignored throughout.
    pred_req = 1; pred_pc = 32'h40;
    wait_sweep(n, saw);
    pred_req = 0;
    chk("sweep_len", n, 64);
    chk("sweep_no_pv", {31'd0, saw}, 32'd0);
    look(32'h0000_0abc, 1'b0, "post_sweep");

    // Saturation on pc 0x100.
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 1'b1, 1'b0);
      look(32'h100, sat_exp_t[i], "sat_taken");
    end
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 1'b0, 1'b0);
      look(32'h100, sat_exp_n[i], "sat_not_taken");
    end

    // Same-cycle lookup/update to an entry at weak-not-taken.
    pred_req = 1; pred_pc = 32'h10;
    upd_valid = 1; upd_pc = 32'h10; upd_taken = 1;
    @(negedge clk);
    idle();
    chk("hazard_old", {31'd0, pt}, 32'd0);
    look(32'h10, 1'b1, "hazard_new");

    // Aliasing: 0x004 and 0x104 share index 1.
    look(32'h104, 1'b0, "alias_before");
    upd(32'h004, 1'b1, 1'b0);
    look(32'h104, 1'b1, "alias_after");

    // Stall during the sweep extends busy by the stalled cycles.
    do_reset();
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
      rdy = !(n >= 5 && n < 15);
    end
    rdy = 1;
    chk("stall_len", n, 74);

    // Reset at sweep index 30 restarts the full sweep.
    do_reset();
    repeat (30) @(negedge clk);
    do_reset();
    wait_sweep(n, saw);
    chk("restart_len", n, 64);
    look(32'h100, 1'b0, "restart_fresh");

    // Statistics: 5 mispredicts among 8 updates.
    for (int i = 0; i < 8; i++) upd(32'h0 + 32'(i * 4), i[0], i < 5);
    chk("stats_cnt", cnt, 32'd5);
    chk("stats_cnt_wrap", {30'd0, cnt2}, 32'd1);

    // Randomised traffic, including stalls, hazards and rare resets.
    for (int i = 0; i < 4000; i++) begin
      rdy       = ($urandom_range(0, 9) != 0);
      rst       = ($urandom_range(0, 799) == 0);
      pred_req  = $urandom_range(0, 1);
      pred_pc   = $urandom & 32'h0000_03ff;
      upd_valid = $urandom_range(0, 1);
      upd_pc    = ($urandom_range(0, 2) == 0) ? pred_pc : ($urandom & 32'h0000_03ff);
      upd_taken = $urandom_range(0, 1);
      upd_mis   = $urandom_range(0, 1);
      @(negedge clk);
    end
    rst = 0; rdy = 1;
    idle();
    repeat (80) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
